dwt_stream_decomposer: RTL and testbench
========================================

Name: dwt_stream_decomposer

Overview:
- Streaming, fully parametrised multi-level discrete wavelet decomposer for the QRS detection path.
- Sits after the ECG pre-filter and feeds the detail-band thresholding logic.
- Each level is a 4-tap QMF filter pair with true decimation by 2. Each level keeps its own tap delay line, and level k+1 consumes the approximation stream of level k.
- Outputs are rounded and saturated, with per-level overflow flags and a synchronous flush.

Parameters:
- DATA_W, 16, signed sample width for the input, every detail output and the approximation output.
- COEF_W, 16, signed coefficient width.
- FRAC, 10, fractional bits of the coefficients; the result is shifted right by FRAC.
- LEVELS, 4, number of decomposition levels (1..8).
- H0, 495, low-pass tap 0 (db4 × 1024).
- H1, 857, low-pass tap 1.
- H2, 229, low-pass tap 2.
- H3, -132, low-pass tap 3.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous flush; same effect as reset, taken on the clock edge
- in_valid  in  1  input sample strobe; at most one sample per cycle; no backpressure
- in_data  in  DATA_W  signed input sample
- d_valid  out  LEVELS  bit k strobes one cycle with the level k+1 detail output
- d_data  out  LEVELS*DATA_W  detail level k+1 at [k*DATA_W +: DATA_W]; held between strobes
- a_valid  out  1  strobe for the final-level approximation
- a_data  out  DATA_W  final-level approximation; held between strobes
- overflow  out  LEVELS  sticky flag: saturation occurred at that level

Behaviour:
- Reset is driven by rst (asynchronous, active-high) on clock clk. rst or clr clears:
  - all tap registers, sample counters and phase bits;
  - d_valid, d_data, a_valid, a_data and overflow, all to 0.
- rst/clr arriving mid-stream discards partial pairs. clr takes priority over in_valid in the same cycle.
- High-pass taps are derived, not parameters: G0=H3, G1=-H2, G2=H1, G3=-H0 (defaults -132, -229, 857, -495).
- Per level, on each accepted sample x[n]:
  - shift the taps (x[n], x[n-1], x[n-2], x[n-3]);
  - toggle the phase bit;
  - increment a 2-bit fill counter that saturates at 3.
- Output fires when the fill counter shows the 4th or a later sample and the sample index is even, i.e. n = 4, 6, 8, …
- On a firing sample:
  - A = H0*x[n] + H1*x[n-1] + H2*x[n-2] + H3*x[n-3]
  - D = G0*x[n] + G1*x[n-1] + G2*x[n-2] + G3*x[n-3]
- Arithmetic rules:
  - accumulator width is DATA_W+COEF_W+2, signed;
  - round by adding 2^(FRAC-1), then arithmetic shift right by FRAC (round-half-up, floor for negatives);
  - saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Saturation of either A or D sets overflow[level]. The flag stays set until rst or clr.
- Latency and output registers:
  - level outputs are registered one cycle after the firing sample's in_valid or upstream strobe;
  - D(level k) goes to d_data slot k-1;
  - A(level k) is the level k+1 input strobe, one cycle after its own firing.
- Level L output needs 4·2^(L-1) + 2·(2^(L-1) - 1) input samples for its first result, and then one result per 2^L samples.
- The final level's A drives a_data/a_valid. Intermediate A values are not exported.
- Rate: input at full rate produces at most half rate at every level, so no stall or buffering is required.
- Simultaneous strobes at different levels in one cycle are legal and independent.
- The input is treated as signed two's complement; no sign-extension differs from in_data.

Test Plan:
- Reset values: assert rst mid-stream → all outputs 0 immediately; after release, the first d_valid[0] occurs only after 4 new samples.
- Constant input 1000, with in_valid every cycle:
  - D1 = 1 and A1 = 1415, first d_valid[0] one cycle after sample 4, then every 2 samples;
  - D2 = 1, first d_valid[1] one cycle after the level-1 strobe from sample 10.
- Impulse: 1024 then zeros → at n=4, D1 = -495 and A1 = -132 (A1 not exported but checked via level 2); at n=6, D1 = 0.
- Saturation: constant 32767 → A1 saturates to 32767 and overflow[0]=1 stays set; clr pulse → overflow=0 and taps flushed.
- Gapped input (in_valid 1 cycle in 3): same output sequence as the constant case; strobes are spaced by the input gaps; d_data holds between strobes.
- clr coincident with in_valid: the sample is dropped and the fill counter is 0 on the next cycle.

Source files
------------

// File: rtl/dwt_stream_decomposer.sv
// Streaming multi-level discrete wavelet decomposer.
// Each level runs a 4-tap QMF pair (low-pass H, high-pass G derived from H)
// with decimation by 2. Level k+1 consumes the approximation strobe of level k.
// Results are rounded half-up, saturated to DATA_W, and flagged per level.
module dwt_stream_decomposer #(
  parameter int                        DATA_W = 16,
  parameter int                        COEF_W = 16,
  parameter int                        FRAC   = 10,
  parameter int                        LEVELS = 4,
  parameter logic signed [COEF_W-1:0]  H0     = 16'sd495,
  parameter logic signed [COEF_W-1:0]  H1     = 16'sd857,
  parameter logic signed [COEF_W-1:0]  H2     = 16'sd229,
  parameter logic signed [COEF_W-1:0]  H3     = -16'sd132
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            in_valid,
  input  logic signed [DATA_W-1:0]        in_data,
  output logic [LEVELS-1:0]               d_valid,
  output logic [LEVELS*DATA_W-1:0]        d_data,
  output logic                            a_valid,
  output logic signed [DATA_W-1:0]        a_data,
  output logic [LEVELS-1:0]               overflow
);

  localparam int ACC_W = DATA_W + COEF_W + 2;

  localparam logic signed [ACC_W-1:0] ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] RND  = ONE <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MAXV = (ONE <<< (DATA_W - 1)) - ONE;
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - ONE;

  localparam logic [DATA_W-1:0] SAT_HI = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_LO = {1'b1, {(DATA_W-1){1'b0}}};

  // Low-pass taps and the mirrored, sign-alternated high-pass taps.
  localparam logic signed [ACC_W-1:0] KH0 = ACC_W'(H0);
  localparam logic signed [ACC_W-1:0] KH1 = ACC_W'(H1);
  localparam logic signed [ACC_W-1:0] KH2 = ACC_W'(H2);
  localparam logic signed [ACC_W-1:0] KH3 = ACC_W'(H3);
  localparam logic signed [ACC_W-1:0] KG0 = KH3;
  localparam logic signed [ACC_W-1:0] KG1 = -KH2;
  localparam logic signed [ACC_W-1:0] KG2 = KH1;
  localparam logic signed [ACC_W-1:0] KG3 = -KH0;

  // Four-tap multiply-accumulate at full accumulator width.
  function automatic logic signed [ACC_W-1:0] mac4(
    input logic signed [DATA_W-1:0] x0,
    input logic signed [DATA_W-1:0] x1,
    input logic signed [DATA_W-1:0] x2,
    input logic signed [DATA_W-1:0] x3,
    input logic signed [ACC_W-1:0]  c0,
    input logic signed [ACC_W-1:0]  c1,
    input logic signed [ACC_W-1:0]  c2,
    input logic signed [ACC_W-1:0]  c3
  );
    mac4 = ACC_W'(x0) * c0 + ACC_W'(x1) * c1 + ACC_W'(x2) * c2 + ACC_W'(x3) * c3;
  endfunction

  // Round half-up, shift out the fraction, saturate; MSB of result is the overflow flag.
  function automatic logic [DATA_W:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + RND) >>> FRAC;
    if (r > MAXV) begin
      round_sat = {1'b1, SAT_HI};
    end else if (r < MINV) begin
      round_sat = {1'b1, SAT_LO};
    end else begin
      round_sat = {1'b0, r[DATA_W-1:0]};
    end
  endfunction

  // Approximation stream of every level, used as the next level's input.
  logic [LEVELS-1:0]        lvl_av_s;
  logic signed [DATA_W-1:0] lvl_a_s [LEVELS];

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    logic                     in_v_s;
    logic signed [DATA_W-1:0] in_d_s;
    logic signed [DATA_W-1:0] t1_r;
    logic signed [DATA_W-1:0] t2_r;
    logic signed [DATA_W-1:0] t3_r;
    logic [1:0]               fill_r;
    logic                     phase_r;
    logic                     fire_s;
    logic signed [ACC_W-1:0]  acc_a_s;
    logic signed [ACC_W-1:0]  acc_d_s;
    logic [DATA_W:0]          res_a_s;
    logic [DATA_W:0]          res_d_s;
    logic                     d_v_r;
    logic signed [DATA_W-1:0] d_r;
    logic                     a_v_r;
    logic signed [DATA_W-1:0] a_r;
    logic                     ovf_r;

    // Level 0 takes the external stream (flush wins over a coincident sample).
    if (k == 0) begin : g_src
      assign in_v_s = in_valid & ~clr;
      assign in_d_s = in_data;
    end else begin : g_src
      assign in_v_s = lvl_av_s[k-1];
      assign in_d_s = lvl_a_s[k-1];
    end

    // Filter pair on the incoming sample plus the three stored taps; fire on even samples from the 4th on.
    always_comb begin
      acc_a_s = mac4(in_d_s, t1_r, t2_r, t3_r, KH0, KH1, KH2, KH3);
      acc_d_s = mac4(in_d_s, t1_r, t2_r, t3_r, KG0, KG1, KG2, KG3);
      res_a_s = round_sat(acc_a_s);
      res_d_s = round_sat(acc_d_s);
      fire_s  = in_v_s & (fill_r == 2'd3) & phase_r;
    end

    // Tap delay line, fill/phase tracking and registered level outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        t1_r    <= {DATA_W{1'b0}};
        t2_r    <= {DATA_W{1'b0}};
        t3_r    <= {DATA_W{1'b0}};
        fill_r  <= 2'd0;
        phase_r <= 1'b0;
        d_v_r   <= 1'b0;
        d_r     <= {DATA_W{1'b0}};
        a_v_r   <= 1'b0;
        a_r     <= {DATA_W{1'b0}};
        ovf_r   <= 1'b0;
      end else if (clr) begin
        t1_r    <= {DATA_W{1'b0}};
        t2_r    <= {DATA_W{1'b0}};
        t3_r    <= {DATA_W{1'b0}};
        fill_r  <= 2'd0;
        phase_r <= 1'b0;
        d_v_r   <= 1'b0;
        d_r     <= {DATA_W{1'b0}};
        a_v_r   <= 1'b0;
        a_r     <= {DATA_W{1'b0}};
        ovf_r   <= 1'b0;
      end else begin
        d_v_r <= 1'b0;
        a_v_r <= 1'b0;
        if (in_v_s) begin
          t1_r    <= in_d_s;
          t2_r    <= t1_r;
          t3_r    <= t2_r;
          phase_r <= ~phase_r;
          if (fill_r != 2'd3) begin
            fill_r <= fill_r + 2'd1;
          end
          if (fire_s) begin
            d_r   <= res_d_s[DATA_W-1:0];
            a_r   <= res_a_s[DATA_W-1:0];
            d_v_r <= 1'b1;
            a_v_r <= 1'b1;
            ovf_r <= ovf_r | res_a_s[DATA_W] | res_d_s[DATA_W];
          end
        end
      end
    end

    assign lvl_av_s[k]                  = a_v_r;
    assign lvl_a_s[k]                   = a_r;
    assign d_valid[k]                   = d_v_r;
    assign d_data[k*DATA_W +: DATA_W]   = d_r;
    assign overflow[k]                  = ovf_r;
  end

  assign a_valid = lvl_av_s[LEVELS-1];
  assign a_data  = lvl_a_s[LEVELS-1];

endmodule

// File: tb/tb_dwt_stream_decomposer.sv
// Bench for dwt_stream_decomposer: directed scenarios plus random traffic,
// every cycle compared against a sample-history reference model.
module tb_dwt_stream_decomposer;

  localparam int LV = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = 16'sd0;
  logic [LV-1:0]      d_valid;
  logic [LV*16-1:0]   d_data;
  logic               a_valid;
  logic signed [15:0] a_data;
  logic [LV-1:0]      overflow;

  dwt_stream_decomposer dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .d_valid  (d_valid),
    .d_data   (d_data),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-level sample count and last four samples (index 0 newest).
  int hc [4] = '{495, 857, 229, -132};
  int gc [4] = '{-132, -229, 857, -495};
  int win [LV][4];
  int cnt [LV];
  bit m_dv [LV];
  int m_d [LV];
  bit m_av [LV];
  int m_a [LV];
  bit m_ovf [LV];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int rnd_sat(input longint s, output bit ov);
    longint r;
    r = (s + 64'sd512) >>> 10;
    ov = 1'b0;
    if (r > 64'sd32767) begin
      r = 64'sd32767;
      ov = 1'b1;
    end else if (r < -64'sd32768) begin
      r = -64'sd32768;
      ov = 1'b1;
    end
    return int'(r);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < LV; k++) begin
      for (int j = 0; j < 4; j++) win[k][j] = 0;
      cnt[k] = 0; m_dv[k] = 1'b0; m_d[k] = 0;
      m_av[k] = 1'b0; m_a[k] = 0; m_ovf[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    bit iv [LV];
    int id [LV];
    longint sa, sd;
    bit oa, od;
    if (c) begin
      model_clear();
      return;
    end
    iv[0] = v; id[0] = d;
    for (int k = 1; k < LV; k++) begin
      iv[k] = m_av[k-1]; id[k] = m_a[k-1];
    end
    for (int k = 0; k < LV; k++) begin
      m_dv[k] = 1'b0; m_av[k] = 1'b0;
    end
    for (int k = 0; k < LV; k++) begin
      if (iv[k]) begin
        for (int j = 3; j > 0; j--) win[k][j] = win[k][j-1];
        win[k][0] = id[k];
        cnt[k]++;
        if (cnt[k] >= 4 && (cnt[k] % 2) == 0) begin
          sa = 0; sd = 0;
          for (int j = 0; j < 4; j++) begin
            sa += longint'(hc[j]) * longint'(win[k][j]);
            sd += longint'(gc[j]) * longint'(win[k][j]);
          end
          m_a[k] = rnd_sat(sa, oa);
          m_d[k] = rnd_sat(sd, od);
          m_dv[k] = 1'b1; m_av[k] = 1'b1;
          if (oa || od) m_ovf[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [LV-1:0]    ev, eo;
    logic [LV*16-1:0] ed;
    for (int k = 0; k < LV; k++) begin
      ev[k] = m_dv[k];
      eo[k] = m_ovf[k];
      ed[k*16 +: 16] = 16'(m_d[k]);
    end
    check_val("d_valid", 64'(d_valid), 64'(ev));
    check_val("d_data", 64'(d_data), 64'(ed));
    check_val("a_valid", 64'(a_valid), 64'(m_av[LV-1]));
    check_val("a_data", 64'(a_data), 64'(16'(m_a[LV-1])));
    check_val("overflow", 64'(overflow), 64'(eo));
  endtask

  task automatic step(input bit v, input logic signed [15:0] d, input bit c);
    @(negedge clk);
    in_valid = v; in_data = d; clr = c;
    model_step(v, int'(d), c);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    @(negedge clk);
    in_valid = 1'b0; clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_val("rst_d_valid", 64'(d_valid), 64'd0);
    check_val("rst_d_data", 64'(d_data), 64'd0);
    check_val("rst_a_data", 64'(a_data), 64'd0);
    check_val("rst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    #12;
    check_val("init_outputs", 64'(d_data), 64'd0);
    check_val("init_flags", 64'({d_valid, a_valid, overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Constant 1000 at full rate: D1 = 1 from sample 4, D2 = 1 from sample 10 + 1 cycle.
    for (int i = 1; i <= 80; i++) begin
      step(1'b1, 16'sd1000, 1'b0);
      if (i == 3) check_val("const_no_early_d1", 64'(d_valid[0]), 64'd0);
      if (i == 4) begin
        check_val("const_first_d1_valid", 64'(d_valid[0]), 64'd1);
        check_val("const_d1_value", 64'(d_data[15:0]), 64'd1);
      end
      if (i == 5) check_val("const_d1_gap", 64'(d_valid[0]), 64'd0);
      if (i == 10) check_val("const_no_early_d2", 64'(d_valid[1]), 64'd0);
      if (i == 11) begin
        check_val("const_first_d2_valid", 64'(d_valid[1]), 64'd1);
        check_val("const_d2_value", 64'(d_data[31:16]), 64'd1);
      end
    end

    // Reset mid-stream, then the first detail needs 4 fresh samples.
    async_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 16'sd1000, 1'b0);
      if (i == 3) check_val("post_rst_no_d1", 64'(d_valid), 64'd0);
      if (i == 4) check_val("post_rst_d1", 64'(d_valid[0]), 64'd1);
    end

    // Impulse: D1 = -495 at n=4, D1 = 0 at n=6.
    step(1'b0, 16'sd0, 1'b1);
    step(1'b1, 16'sd1024, 1'b0);
    for (int i = 2; i <= 30; i++) begin
      step(1'b1, 16'sd0, 1'b0);
      if (i == 4) check_val("impulse_d1_n4", 64'(d_data[15:0]), 64'h0000_0000_0000_fe11);
      if (i == 6) begin
        check_val("impulse_d1_n6_valid", 64'(d_valid[0]), 64'd1);
        check_val("impulse_d1_n6", 64'(d_data[15:0]), 64'd0);
      end
    end

    // Saturation at full scale, sticky flag, then flush.
    step(1'b0, 16'sd0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 16'sd32767, 1'b0);
      if (i == 3) check_val("sat_no_flag_yet", 64'(overflow[0]), 64'd0);
      if (i == 5 || i == 12) check_val("sat_flag_sticky", 64'(overflow[0]), 64'd1);
    end
    step(1'b0, 16'sd0, 1'b1);
    check_val("sat_clr_flag", 64'(overflow), 64'd0);

    // Gapped constant input, one sample in three.
    for (int i = 0; i < 300; i++) step((i % 3) == 0, 16'sd1000, 1'b0);

    // Flush coincident with a sample drops it and restarts filling.
    step(1'b0, 16'sd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 16'sd500, 1'b0);
    step(1'b1, 16'sd500, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 16'sd500, 1'b0);
      if (i == 3) check_val("clr_drop_no_d1", 64'(d_valid[0]), 64'd0);
      if (i == 4) check_val("clr_drop_d1", 64'(d_valid[0]), 64'd1);
    end

    // Random traffic with mixed amplitudes and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      logic signed [15:0] d;
      if ($urandom_range(0, 3) == 0) d = 16'($urandom_range(0, 65535));
      else d = 16'($urandom_range(0, 4095)) - 16'sd2048;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 399) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
